bip_control_unit: RTL

- Multicycle control unit for the 16-bit BIP I processor.
- Fetches 16-bit instructions (opcode[15:11], operand[10:0]) from synchronous program memory and decodes them.
- Drives the ALU operation select, the operand multiplexers, accumulator write enable and data-memory strobes.
- Sits upstream of the ALU and accumulator, acting as initiator of every ALU transaction.

---
 rtl/bip_pkg.sv | 42 ++++
 rtl/bip_decoder.sv | 69 ++++++
 rtl/bip_control_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I control unit: opcodes, FSM state
// encoding, accumulator/ALU select encodings and a small decode helper.
package bip_pkg;

    // Instruction opcodes, IR[15:11]
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEMRD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Accumulator source select
    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    // ALU B-operand source select
    localparam logic SEL_B_MEM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    // ALU operation
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Instructions that fetch a data-memory operand before executing
    function automatic logic needs_memrd(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: turns the IR opcode plus the current
// phase (MEMRD or EXEC) into data-memory strobes, accumulator load and
// ALU/mux selects. Everything is zero outside those two phases.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opcode_i,
    input  logic       exec_i,
    input  logic       memrd_i,
    output logic       data_rd_o,
    output logic       data_wr_o,
    output logic       wr_acc_o,
    output logic       alu_op_o,
    output logic [1:0] sel_a_o,
    output logic       sel_b_o
);

    // Strobe and select decode; defaults keep every strobe inactive
    always_comb begin
        data_rd_o = 1'b0;
        data_wr_o = 1'b0;
        wr_acc_o  = 1'b0;
        alu_op_o  = ALU_ADD;
        sel_a_o   = SEL_A_MEM;
        sel_b_o   = SEL_B_MEM;
        if (memrd_i) begin
            data_rd_o = 1'b1;
        end
        if (exec_i) begin
            case (opcode_i)
                OP_STO: data_wr_o = 1'b1;
                OP_LD: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_MEM;
                end
                OP_LDI: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_IMM;
                end
                OP_ADD: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_ALU;
                    sel_b_o  = SEL_B_MEM;
                    alu_op_o = ALU_ADD;
                end
                OP_ADDI: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_ALU;
                    sel_b_o  = SEL_B_IMM;
                    alu_op_o = ALU_ADD;
                end
                OP_SUB: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_ALU;
                    sel_b_o  = SEL_B_MEM;
                    alu_op_o = ALU_SUB;
                end
                OP_SUBI: begin
                    wr_acc_o = 1'b1;
                    sel_a_o  = SEL_A_ALU;
                    sel_b_o  = SEL_B_IMM;
                    alu_op_o = ALU_SUB;
                end
                default: ; // HLT never reaches EXEC; undefined opcodes are NOPs
            endcase
        end
    end

endmodule

// File: rtl/bip_control_unit.sv
// Multicycle control unit for the 16-bit BIP I processor.
// FETCH -> DECODE -> [MEMRD] -> EXEC -> FETCH, or DECODE -> HALT.
// Outputs are Moore: they depend only on the state and IR registers.
// Optional instruction counter: define BIP_INSTR_COUNT_EN to add the
// instr_count output.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int              PC_W     = 11,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [15:0]     instr_data,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] operand,
    output logic            data_rd,
    output logic            data_wr,
    output logic            alu_op,
    output logic [1:0]      sel_a,
    output logic            sel_b,
    output logic            wr_acc,
`ifdef BIP_INSTR_COUNT_EN
    output logic [31:0]     instr_count,
`endif
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    // State, PC and IR registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; with enable low everything holds, HALT is terminal
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (enable) begin
            case (state_q)
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d = instr_data;
                    if (instr_data[15:11] == OP_HLT) begin
                        state_d = ST_HALT;
                    end else if (needs_memrd(instr_data[15:11])) begin
                        state_d = ST_MEMRD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_MEMRD: state_d = ST_EXEC;
                ST_EXEC: begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    bip_decoder u_decoder (
        .opcode_i  (ir_q[15:11]),
        .exec_i    (state_q == ST_EXEC),
        .memrd_i   (state_q == ST_MEMRD),
        .data_rd_o (data_rd),
        .data_wr_o (data_wr),
        .wr_acc_o  (wr_acc),
        .alu_op_o  (alu_op),
        .sel_a_o   (sel_a),
        .sel_b_o   (sel_b)
    );

    assign pc      = pc_q;
    assign operand = PC_W'(ir_q[10:0]);
    assign halted  = (state_q == ST_HALT);

`ifdef BIP_INSTR_COUNT_EN
    logic [31:0] count_q;

    // Counts enabled EXEC cycles; a stalled EXEC is counted only once
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (enable && (state_q == ST_EXEC)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
